uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clk cycles per serial bit (100 MHz / 115200 baud).
REQ-002 Parameter DEPTH, default 64, SHALL set FIFO entries; power of two only.
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 rx  input  1  SHALL carry the asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rd_en  input  1  SHALL be the pop request, sampled each cycle.
REQ-007 data_out  output  8  SHALL hold the registered popped byte.
REQ-008 data_valid  output  1  SHALL pulse 1 cycle when data_out is updated.
REQ-009 fifo_empty  output  1  SHALL be high when count == 0.
REQ-010 fifo_full  output  1  SHALL be high when count == DEPTH.
REQ-011 count  output  log2(DEPTH)+1  SHALL give stored entries.
REQ-012 frame_err  output  1  SHALL pulse 1 cycle on a bad stop bit.
REQ-013 overrun  output  1  SHALL pulse 1 cycle when a received byte is dropped because the FIFO is full.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on synchronized rx == 0; the bit counter clears.
REQ-017 START SHALL sample rx at CLKS_PER_BIT/2 cycles after entry: low -> DATA, high -> IDLE (false start, nothing pushed).
REQ-018 DATA SHALL sample every CLKS_PER_BIT cycles, shift LSB first, and move to STOP after the 8th bit.
REQ-019 STOP SHALL sample CLKS_PER_BIT cycles after bit 7.
  - high: the byte is pushed on the next cycle, then IDLE.
  - low: frame_err pulses, the byte is discarded, and the FSM stays in STOP until rx is high, then IDLE.
REQ-020 Push when fifo_full SHALL drop the byte, pulse overrun, and leave pointers and contents unchanged.
REQ-021 rd_en with !fifo_empty SHALL load data_out from the read pointer on the next edge, assert data_valid that cycle, and advance the read pointer.
REQ-022 rd_en with fifo_empty SHALL be ignored: no data_valid, data_out holds.
REQ-023 Simultaneous push and pop SHALL both occur with count unchanged; this is legal when full (pop frees a slot) and when empty (no pop, push only).
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL derive from count, not pointer equality.
REQ-025 A pushed byte SHALL be poppable on the cycle after the push (fifo_empty falls 1 cycle after push).

Reset
REQ-026 rst high SHALL immediately force:
  - FSM to IDLE; pointers, count and bit/baud counters to 0;
  - data_out to 0x00; data_valid, frame_err and overrun to 0; fifo_empty to 1; fifo_full to 0;
  - synchronizer flops to 1.
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release, reception SHALL resume only on the next falling edge.
REQ-028 FIFO storage SHALL NOT require reset.

Structure
REQ-029 Shared package uart_pkg SHALL hold the CLKS_PER_BIT and DEPTH defaults and the rx state enum; the TX FIFO/transmitter side SHALL use the same package.
REQ-030 The deserializer (synchronizer, FSM, baud counter) SHALL be sub-module uart_rx, outputting byte and byte_valid; uart_rx_fifo SHALL instantiate it and contain the FIFO.

Verification (CLKS_PER_BIT = 16, DEPTH = 4 allowed on bench)
REQ-031 Send 0xA5 then pulse rd_en -> data_out = 0xA5 with data_valid 1 cycle after rd_en; fifo_empty back to 1.
REQ-032 Send 5 bytes 0x01..0x05 with no reads -> count = 4, overrun pulses once on byte 5, pops return 0x01..0x04.
REQ-033 Send 0x3C with stop bit low, then 0x5A -> frame_err pulses once; only 0x5A is stored.
REQ-034 Hold rx low for 4 clocks, then high -> no push, FSM back in IDLE, count = 0.
REQ-035 With FIFO full, assert rd_en on the push cycle -> count stays 4, no overrun, order preserved across pointer wrap.
REQ-036 Assert rst during bit 3 of 0xFF, release, send 0x11 -> only 0x11 is stored; all outputs are at reset values during rst.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit slice: default timing,
// FIFO depth and the receiver state encoding.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DEPTH        = 64;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserializer: synchronizes the serial line, tracks bit timing and
// emits one registered byte per good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_byte,
  output logic                 byte_valid,
  output logic                 frame_err
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_hold;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      stop_hold  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          stop_hold <= 1'b0;
          if (!rx_sync) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // After a bad stop bit, park here until the line returns high.
        STOP: begin
          if (stop_hold) begin
            if (rx_sync) begin
              stop_hold <= 1'b0;
              state     <= IDLE;
            end
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              data_byte  <= shift_reg;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_hold <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a DEPTH-entry byte FIFO with registered pop output,
// overrun and framing-error pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_byte (rx_byte),
    .byte_valid(rx_byte_valid),
    .frame_err (frame_err)
  );

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = rd_en && (count != '0);
  assign do_push = rx_byte_valid && ((count != FULL_COUNT) || do_pop);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= do_pop;
      overrun    <= rx_byte_valid && !do_push;
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
